// File: rtl/rx2fifoc_if.sv
// Link-receiver / command-FIFO / parser handshake bundle for rx2fifoc.
interface rx2fifoc_if;
   logic       rxv;
   logic [7:0] rxd;
   logic       fifoc_full;
   logic       fifoc_txen;
   logic [7:0] fifoc_txd;
   logic       fs;
   logic       fd;
   logic       err;
   logic [7:0] so;

   modport slave  (input  rxv, rxd, fifoc_full, fd,
                   output fifoc_txen, fifoc_txd, fs, err, so);
   modport master (output rxv, rxd, fifoc_full, fd,
                   input  fifoc_txen, fifoc_txd, fs, err, so);
endinterface

// File: rtl/rx2fifoc.sv
// Frames 55 AA C0..C8 K packets from a byte link, checks the sum, copies them to a command FIFO.
// Optional inter-byte timeout enabled by defining RX2FIFOC_TIMEOUT_EN.
module rx2fifoc #(
   parameter logic [15:0] TOUT = 16'd1000
) (
   input  logic       clk,
   input  logic       rst,
   rx2fifoc_if.slave  bus
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HED1 = 3'd1;
   localparam logic [2:0] BODY = 3'd2;
   localparam logic [2:0] CHK  = 3'd3;
   localparam logic [2:0] WRIT = 3'd4;
   localparam logic [2:0] HAND = 3'd5;
   localparam logic [2:0] WAIT = 3'd6;

   logic [2:0] state, state_nx;
   logic [3:0] cnt;         // body byte counter, reused as write index
   logic [7:0] sum;
   logic [7:0] chk;
   logic [7:0] cbuf [0:8];
   logic [7:0] wr_byte;
   logic       tmo;
   logic       in_frame;

   assign in_frame = (state == HED1) || (state == BODY);

`ifdef RX2FIFOC_TIMEOUT_EN
   logic [15:0] timer;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       timer <= 16'd0;
      else if (bus.rxv || !in_frame)  timer <= 16'd0;
      else                            timer <= timer + 16'd1;
   end

   // A strobe in the expiry cycle wins: tmo is masked by rxv.
   assign tmo = in_frame && !bus.rxv && (timer == TOUT - 16'd1);
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.rxv && bus.rxd == 8'h55) state_nx = HED1;
         HED1: begin
            if (tmo)
               state_nx = IDLE;
            else if (bus.rxv) begin
               if (bus.rxd == 8'hAA)      state_nx = BODY;
               else if (bus.rxd != 8'h55) state_nx = IDLE;
            end
         end
         BODY: begin
            if (tmo)                            state_nx = IDLE;
            else if (bus.rxv && cnt == 4'd9)    state_nx = CHK;
         end
         CHK:  state_nx = (sum == chk) ? WRIT : IDLE;
         WRIT: if (!bus.fifoc_full && cnt == 4'd11) state_nx = HAND;
         HAND: if (bus.fd)  state_nx = WAIT;
         WAIT: if (!bus.fd) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 4'd0;
         sum <= 8'd0;
         chk <= 8'd0;
         for (int i = 0; i < 9; i++) cbuf[i] <= 8'd0;
      end else begin
         case (state)
            HED1: begin
               cnt <= 4'd0;
               sum <= 8'd0;
            end
            BODY: if (bus.rxv) begin
               if (cnt == 4'd9) chk <= bus.rxd;
               else begin
                  cbuf[cnt] <= bus.rxd;
                  sum       <= sum + bus.rxd;
               end
               cnt <= cnt + 4'd1;
            end
            CHK:  cnt <= 4'd0;
            WRIT: if (!bus.fifoc_full) cnt <= cnt + 4'd1;
            default: ;
         endcase
      end
   end

   // Replay order: header, the nine stored bytes, then the checksum.
   always_comb begin
      wr_byte = 8'h00;
      if (cnt == 4'd0)       wr_byte = 8'h55;
      else if (cnt == 4'd1)  wr_byte = 8'hAA;
      else if (cnt <= 4'd10) wr_byte = cbuf[cnt - 4'd2];
      else if (cnt == 4'd11) wr_byte = chk;
   end

   assign bus.fifoc_txen = (state == WRIT) && !bus.fifoc_full;
   assign bus.fifoc_txd  = (state == WRIT) ? wr_byte : 8'h00;
   assign bus.fs         = (state == HAND);
   assign bus.err        = ((state == CHK) && (sum != chk)) || tmo;
   assign bus.so         = {5'b00000, state};
endmodule
